// File: rtl/ps_linebuffer.sv
// Circular 8-bit pixel line buffer with independent write and read pointers.
// Each read registers a three-pixel window that wraps around the end of the line.
module ps_linebuffer #(
    parameter int LINE_LENGTH = 640
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_wr,
    input  logic [7:0]  i_wdata,
    input  logic        i_rd,
    output logic [23:0] o_rdata
);

    localparam int PW = $clog2(LINE_LENGTH);
    localparam logic [PW:0] L_EXT = LINE_LENGTH[PW:0];

    logic [7:0]    r_mem [LINE_LENGTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [23:0]   r_rdata;

    logic [PW-1:0] w_wptr_next;
    logic [PW-1:0] w_tap_idx [3];
    logic [23:0]   w_window;

    // Pointer plus a small offset, folded back into 0..LINE_LENGTH-1.
    function automatic logic [PW-1:0] f_wrap_add(input logic [PW-1:0] p, input logic [1:0] k);
        logic [PW:0] s;
        s = {1'b0, p} + {{(PW-1){1'b0}}, k};
        if (s >= L_EXT) begin
            s = s - L_EXT;
        end
        return s[PW-1:0];
    endfunction

    assign w_wptr_next = f_wrap_add(r_wptr, 2'd1);

    // Tap 0 is the oldest pixel and lands in the top byte of the window.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tap
            assign w_tap_idx[gi]             = f_wrap_add(r_rptr, 2'(gi));
            assign w_window[23-8*gi -: 8]    = r_mem[w_tap_idx[gi]];
        end
    endgenerate

    // Storage carries no reset so it maps onto RAM; a same-edge read sees the old value.
    always_ff @(posedge i_clk) begin
        if (i_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_rdata <= '0;
        end else begin
            if (i_wr) begin
                r_wptr <= w_wptr_next;
            end
            if (i_rd) begin
                r_rptr  <= w_tap_idx[1];
                r_rdata <= w_window;
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: tb/tb_ps_linebuffer.sv
// Scoreboard bench for ps_linebuffer: a queue-based line model predicts each read window,
// and a monitor compares every registered window and every held value against it.
module tb_ps_linebuffer;

    localparam int L = 640;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic [23:0] rdata;

    always #5 clk = ~clk;

    ps_linebuffer #(.LINE_LENGTH(L)) dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_wr    (wr),
        .i_wdata (wdata),
        .i_rd    (rd),
        .o_rdata (rdata)
    );

    logic [7:0]  mdl_mem [L];
    int          mdl_wp = 0;
    int          mdl_rp = 0;
    logic [23:0] exp_q [$];
    logic [23:0] last_exp = 24'h0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %06h, required %06h", name, act, req);
    endtask

    // One clock: drive at negedge, predict from the pre-write model, then update the model.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r);
        @(negedge clk);
        wr = w; wdata = d; rd = r;
        if (r) exp_q.push_back({mdl_mem[mdl_rp], mdl_mem[(mdl_rp + 1) % L], mdl_mem[(mdl_rp + 2) % L]});
        if (w) begin
            mdl_mem[mdl_wp] = d;
            mdl_wp = (mdl_wp + 1) % L;
        end
        if (r) mdl_rp = (mdl_rp + 1) % L;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        #1 rstn = 1'b0;
        #1 check(name, rdata, 24'h0);
        mdl_wp = 0;
        mdl_rp = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    always @(posedge clk) begin : mon_blk
        bit rd_s;
        if (!rstn) begin
            last_exp = 24'h0;
        end else begin
            rd_s = rd;
            #1;
            if (rd_s) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL window: got %06h, required none (no prediction queued)", rdata);
                end else begin
                    last_exp = exp_q.pop_front();
                    check("window", rdata, last_exp);
                end
            end else begin
                check("hold", rdata, last_exp);
            end
        end
    end

    initial begin
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_state", rdata, 24'h0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < L; i++) cycle(1'b1, 8'(i + 1), 1'b0);
        for (int k = 1; k <= L; k++) begin
            cycle(1'b0, 8'h00, 1'b1);
            if (k == 1)   check("first_read", rdata, 24'h010203);
            if (k == 2)   check("second_read", rdata, 24'h020304);
            if (k == 638) check("read_638", rdata, 24'h7E7F80);
            if (k == 639) check("wrap_639", rdata, 24'h7F8001);
            if (k == 640) check("wrap_640", rdata, 24'h800102);
        end

        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        check("overwrite_entry0", rdata, 24'hAA0203);

        cycle(1'b0, 8'h00, 1'b1);
        check("pre_idle_read", rdata, 24'h020304);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            check("idle_hold", rdata, 24'h020304);
        end
        cycle(1'b0, 8'h00, 1'b1);
        check("resume_read", rdata, 24'h030405);

        cycle(1'b0, 8'h00, 1'b1);
        check("before_async_reset", rdata, 24'h040506);
        rd = 1'b0;
        #1 rstn = 1'b0;
        #1 check("async_reset", rdata, 24'h0);
        mdl_wp = 0;
        mdl_rp = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cycle(1'b0, 8'h00, 1'b1);
        check("retained_after_reset", rdata, 24'hAA0203);

        do_reset("reset_before_collision");
        cycle(1'b1, 8'h11, 1'b0);
        for (int i = 1; i < L; i++) cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b1, 8'h55, 1'b1);
        check("collision_old_value", {16'h0, rdata[23:16]}, 24'h000011);
        do_reset("reset_after_collision");
        cycle(1'b0, 8'h00, 1'b1);
        check("collision_new_value", {16'h0, rdata[23:16]}, 24'h000055);

        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        @(posedge clk);
        #3;
        check("queue_drain", 24'(exp_q.size()), 24'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
